// File: rtl/piece_queue_pkg.sv
// -----------------------------------------------------------------------------
// piece_queue_pkg
// Shared Tetris definitions for the piece queue slice: default piece-ID width,
// number of legal pieces, the piece ID constants, the queue FSM state encodings
// and a small width helper for counters.
// No ports (package).
// -----------------------------------------------------------------------------
package piece_queue_pkg;

    localparam int PIECE_W    = 3;
    localparam int NUM_PIECES = 5;

    // Piece IDs as produced by the LFSR generator.
    localparam logic [PIECE_W-1:0] PIECE_I = 3'd0;
    localparam logic [PIECE_W-1:0] PIECE_O = 3'd1;
    localparam logic [PIECE_W-1:0] PIECE_T = 3'd2;
    localparam logic [PIECE_W-1:0] PIECE_L = 3'd3;
    localparam logic [PIECE_W-1:0] PIECE_S = 3'd4;

    // Queue FSM states (plain constants so older code can reuse them).
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/piece_shift_reg.sv
// -----------------------------------------------------------------------------
// piece_shift_reg
// DEPTH x PIECE_W register array holding the queued piece IDs. An entry can be
// written at an index, or the whole array shifted down one place (entry[i] takes
// entry[i+1], the top entry is cleared). Shift has priority over write.
// Ports:
//   clock        in   system clock
//   srst         in   synchronous active-high reset, clears every entry
//   wr_en        in   write wr_data into entry[wr_idx]
//   wr_idx       in   target entry of a write
//   wr_data      in   piece ID to write
//   shift_en     in   shift all entries down one place
//   entries_flat out  entry[i] at bits [PIECE_W*i +: PIECE_W]
// -----------------------------------------------------------------------------
module piece_shift_reg #(
    parameter int DEPTH   = 3,
    parameter int PIECE_W = 3,
    parameter int IDX_W   = 2
) (
    input  logic                       clock,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [PIECE_W-1:0]         wr_data,
    input  logic                       shift_en,
    output logic [PIECE_W*DEPTH-1:0]   entries_flat
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PIECE_W-1:0] entry_reg;
            logic [PIECE_W-1:0] shift_in;

            // The top entry has nothing above it and is refilled with zero.
            if (gi == DEPTH - 1) begin : g_top
                assign shift_in = '0;
            end else begin : g_mid
                assign shift_in = g_entry[gi+1].entry_reg;
            end

            always_ff @(posedge clock) begin
                if (srst) begin
                    entry_reg <= '0;
                end else if (shift_en) begin
                    entry_reg <= shift_in;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entries_flat[PIECE_W*gi +: PIECE_W] = entry_reg;
        end
    endgenerate

endmodule

// File: rtl/piece_queue.sv
// -----------------------------------------------------------------------------
// piece_queue
// Keeps a DEPTH-entry FIFO of upcoming Tetris piece IDs fed from the free-running
// LFSR value. Codes >= NUM_PIECES are dropped, and an immediate repeat of the
// newest queued piece is rejected up to REROLL_MAX times in a row. The head is
// handed to the game FSM on pop; the other entries form the preview.
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-high reset, dominates pop
//   rnd_in       in   random piece code, sampled every cycle while filling
//   pop          in   consume the head piece, honoured only when ready=1
//   ready        out  queue full, piece_id and preview valid
//   piece_id     out  head entry (entry[0])
//   preview      out  entry[k] at bits [PIECE_W*k-1 -: PIECE_W], k=1..DEPTH-1
//   pieces_dealt out  number of accepted pops, saturating at all-ones
// -----------------------------------------------------------------------------
module piece_queue
    import piece_queue_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int PIECE_W    = piece_queue_pkg::PIECE_W,
    parameter int NUM_PIECES = piece_queue_pkg::NUM_PIECES,
    parameter int REROLL_MAX = 1,
    parameter int COUNT_W    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PIECE_W-1:0]           rnd_in,
    input  logic                         pop,
    output logic                         ready,
    output logic [PIECE_W-1:0]           piece_id,
    output logic [PIECE_W*(DEPTH-1)-1:0] preview,
    output logic [COUNT_W-1:0]           pieces_dealt
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int RR_W  = cnt_width(REROLL_MAX);

    localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PIECE_W:0]   NUM_C    = (PIECE_W+1)'(NUM_PIECES);
    localparam logic [RR_W-1:0]    RR_MAX_C = RR_W'(REROLL_MAX);

    logic [0:0]            state_reg,   state_next;
    logic [CNT_W-1:0]      count_reg,   count_next;
    logic [PIECE_W-1:0]    last_id_reg, last_id_next;
    logic                  last_vld_reg, last_vld_next;
    logic [RR_W-1:0]       reroll_reg,  reroll_next;
    logic [COUNT_W-1:0]    dealt_reg,   dealt_next;

    logic                  code_invalid;
    logic                  is_repeat;
    logic                  do_pop;
    logic                  can_sample;
    logic                  accept;
    logic [PIECE_W*DEPTH-1:0] entries_flat;

    assign code_invalid = ({1'b0, rnd_in} >= NUM_C);
    // Repeat rejection only counts once a piece has been queued since reset.
    assign is_repeat    = last_vld_reg && (rnd_in == last_id_reg) && (reroll_reg < RR_MAX_C);
    assign do_pop       = (state_reg == ST_READY) && pop;
    assign can_sample   = (state_reg == ST_FILL) && (count_reg != DEPTH_C);
    assign accept       = can_sample && !code_invalid && !is_repeat;

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        last_id_next  = last_id_reg;
        last_vld_next = last_vld_reg;
        reroll_next   = reroll_reg;
        dealt_next    = dealt_reg;

        if (do_pop) begin
            // last_id/last_vld survive the pop so the refill is checked
            // against the newest piece still in the queue.
            state_next = ST_FILL;
            count_next = DEPTH_C - CNT_W'(1);
            if (dealt_reg != '1) begin
                dealt_next = dealt_reg + COUNT_W'(1);
            end
        end else if (can_sample && !code_invalid) begin
            if (is_repeat) begin
                reroll_next = reroll_reg + RR_W'(1);
            end else begin
                count_next    = count_reg + CNT_W'(1);
                last_id_next  = rnd_in;
                last_vld_next = 1'b1;
                reroll_next   = '0;
                if (count_reg + CNT_W'(1) == DEPTH_C) begin
                    state_next = ST_READY;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_FILL;
            count_reg    <= '0;
            last_id_reg  <= '0;
            last_vld_reg <= 1'b0;
            reroll_reg   <= '0;
            dealt_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            last_id_reg  <= last_id_next;
            last_vld_reg <= last_vld_next;
            reroll_reg   <= reroll_next;
            dealt_reg    <= dealt_next;
        end
    end

    piece_shift_reg #(
        .DEPTH   (DEPTH),
        .PIECE_W (PIECE_W),
        .IDX_W   (CNT_W)
    ) u_shift (
        .clock        (clock),
        .srst         (reset),
        .wr_en        (accept),
        .wr_idx       (count_reg),
        .wr_data      (rnd_in),
        .shift_en     (do_pop),
        .entries_flat (entries_flat)
    );

    assign ready        = (state_reg == ST_READY);
    assign piece_id     = entries_flat[PIECE_W-1:0];
    assign pieces_dealt = dealt_reg;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_preview
            assign preview[PIECE_W*gi-1 -: PIECE_W] = entries_flat[PIECE_W*gi +: PIECE_W];
        end
    endgenerate

endmodule
